drive_input_conditioner: RTL and testbench
==========================================

# drive_input_conditioner

Front-end conditioning stage between the board's raw buttons and switches and the car driving-mode state machine. It synchronizes every input to `clk`. It debounces the four push buttons and turns the power buttons into single-cycle command pulses, including the 1 s long-press required for power-on. Its outputs connect one-to-one to the driving FSM's `powerOn`, `powerOff`, `turnLeft`, `turnRight` and switch inputs.

## Interface
- `DB_CYCLES`, default 2_000_000: consecutive stable synchronized samples required to accept a button change (20 ms at 100 MHz); must be ≥ 2.
- `HOLD_CYCLES`, default 100_000_000: debounced power-on hold length before `powerOn` fires (1 s at 100 MHz); must be ≥ 2.
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `btn_on_raw`, `btn_off_raw`, `btn_left_raw`, `btn_right_raw` in 1 each: raw, bouncing, asynchronous buttons (1 = pressed).
- `sw_raw` in 5: raw switches {moduleChange, throttle, clutch, brake, rgShift}, MSB first.
- `powerOn` out 1: one-cycle pulse on a completed long-press.
- `powerOff` out 1: one-cycle pulse on a debounced press.
- `turnLeft`, `turnRight` out 1 each: debounced levels.
- `sw_sync` out 5: switches after a 2-flop synchronizer, same bit order; not debounced.

## Operation
- All raw inputs pass through a 2-flop synchronizer. `s` denotes the second flop.
- Per button debounce cell, holding accepted level `d` and counter `cnt`:
  - `s == d`: `cnt` ← 0.
  - `s != d` and `cnt == DB_CYCLES-1`: `d` ← `s`, `cnt` ← 0.
  - Otherwise `cnt` increments.
  - Any bounce back to `d` restarts the count.
- `turnLeft`/`turnRight` = `d` of the respective cell. Both high is passed through unchanged; the FSM resolves it.
- `powerOff` = registered rising edge of the off-cell `d`.
- Hold counter `hcnt`, width `$clog2(HOLD_CYCLES)`:
  - Cleared while on-cell `d` is 0 or off-cell `d` is 1.
  - Otherwise increments and saturates at `HOLD_CYCLES-1`.
  - `powerOn` pulses exactly once, in the cycle `hcnt` reaches `HOLD_CYCLES-1`.
  - No repeat until the button is released and re-held.
- Simultaneous events: power-off dominates. While off-cell `d` is 1, `hcnt` is held at 0 and `powerOn` cannot fire. `powerOn` and `powerOff` are never high in the same cycle.

## Timing
- Reset values: every synchronizer flop, `d`, `cnt`, `hcnt` = 0. Outputs `powerOn`, `powerOff`, `turnLeft`, `turnRight` = 0 and `sw_sync` = 5'b00000.
- `sw_sync` latency: 2 edges after the raw change is first sampled.
- Button latency, with edge 0 = first edge sampling the new clean raw level:
  - `d` changes at edge `DB_CYCLES+1`.
  - `turnLeft`/`turnRight` follow in the same edge.
  - `powerOff` goes high 1 edge later, for 1 cycle.
- `powerOn` is high in the cycle after the edge where `hcnt` reaches `HOLD_CYCLES-1`. That is `HOLD_CYCLES` edges after the on-cell `d` rose.
- Reset mid-operation clears all counters immediately and asynchronously. A button still held at reset release is re-debounced from `d = 0`, so it produces fresh `powerOff`/`powerOn` events.
- No combinational path from any input to any output.

## Configuration
- `PWR_HOLD_EN` defined: long-press power-on as described above.
- `PWR_HOLD_EN` undefined:
  - `hcnt` and its logic are removed and `HOLD_CYCLES` is ignored.
  - `powerOn` is a one-cycle pulse on the debounced rising edge of the on-cell, same timing as `powerOff`.
  - The off-press still suppresses it in the same cycle.

## Structure
- Shared package `drive_pkg` holds:
  - `DB_CYCLES`/`HOLD_CYCLES` defaults.
  - The switch-bit index constants (`SW_MODULE`=4 … `SW_RG`=0).
  - The FSM state encodings shared with the driving FSM.
- One sub-module, `debounce_cell` (parameter `DB_CYCLES`; ports `clk`, `rst`, `raw`, `level`, `rise`). It includes its own 2-flop synchronizer and is instantiated four times.

## Test plan
Bench parameters: `DB_CYCLES`=4, `HOLD_CYCLES`=16.
- Left button, clean press at edge 0 → `turnLeft` = 1 from edge 5. Release → `turnLeft` = 0 five edges later.
- Off button bounces 1,0,1,0 each cycle, then holds 1 → exactly one `powerOff` pulse, 6 edges after the stable level starts; no pulse during the bounce.
- On button held 30 cycles, with `PWR_HOLD_EN` → one `powerOn` pulse 21 edges after press, none after. Release and hold 10 cycles → no pulse. Without `PWR_HOLD_EN` → pulse at edge 6.
- On held, off pressed at cycle 10 → `powerOff` pulses, `powerOn` never fires while off is held, and never together with `powerOff`.
- `sw_raw` = 5'b10110 → `sw_sync` = 5'b10110 after 2 edges.
- `rst` asserted mid-hold while buttons are held → all outputs 0 immediately. After release, the held off button gives `powerOff` at edge 6 again.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared definitions for the driving-mode front end and the driving FSM:
// timing defaults, switch bit positions and the FSM state encoding.
package drive_pkg;

   // 20 ms debounce and 1 s power-on hold at 100 MHz
   localparam int unsigned DEF_DB_CYCLES   = 2_000_000;
   localparam int unsigned DEF_HOLD_CYCLES = 100_000_000;

   // Switch vector layout {moduleChange, throttle, clutch, brake, rgShift}
   localparam int unsigned SW_WIDTH    = 5;
   localparam int unsigned SW_MODULE   = 4;
   localparam int unsigned SW_THROTTLE = 3;
   localparam int unsigned SW_CLUTCH   = 2;
   localparam int unsigned SW_BRAKE    = 1;
   localparam int unsigned SW_RG       = 0;

   // Driving FSM states
   typedef enum logic [2:0] {
      ST_OFF,
      ST_IDLE,
      ST_FORWARD,
      ST_REVERSE,
      ST_TURN_LEFT,
      ST_TURN_RIGHT
   } drive_state_t;

endpackage

// File: rtl/drive_input_conditioner_if.sv
// Board-side raw inputs and conditioned outputs of the input conditioner.
// slave: the conditioner itself; master: the board / stimulus side.
interface drive_input_conditioner_if;
   import drive_pkg::*;

   logic                btn_on_raw;
   logic                btn_off_raw;
   logic                btn_left_raw;
   logic                btn_right_raw;
   logic [SW_WIDTH-1:0] sw_raw;

   logic                powerOn;
   logic                powerOff;
   logic                turnLeft;
   logic                turnRight;
   logic [SW_WIDTH-1:0] sw_sync;

   modport master (
      output btn_on_raw, btn_off_raw, btn_left_raw, btn_right_raw, sw_raw,
      input  powerOn, powerOff, turnLeft, turnRight, sw_sync
   );

   modport slave (
      input  btn_on_raw, btn_off_raw, btn_left_raw, btn_right_raw, sw_raw,
      output powerOn, powerOff, turnLeft, turnRight, sw_sync
   );

endinterface

// File: rtl/debounce_cell.sv
// One button: 2-flop synchronizer, stable-count debouncer and a registered
// rising-edge pulse of the accepted level.
module debounce_cell
   import drive_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int unsigned CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic          d;
   logic          d_prev;
   logic [CW-1:0] cnt;

   // bring the asynchronous button into the clk domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // accept a new level only after DB_CYCLES consecutive differing samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d   <= 1'b0;
         cnt <= '0;
      end else if (s2 == d) begin
         cnt <= '0;
      end else if (cnt == CNT_MAX) begin
         d   <= s2;
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // one-cycle pulse the edge after the accepted level goes high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_prev <= 1'b0;
         rise   <= 1'b0;
      end else begin
         d_prev <= d;
         rise   <= d & ~d_prev;
      end
   end

   assign level = d;

endmodule

// File: rtl/drive_input_conditioner.sv
// Input conditioner in front of the driving-mode FSM: synchronizes the
// switches, debounces the four buttons and forms the power commands.
// PWR_HOLD_EN defined: powerOn needs a HOLD_CYCLES long press of the on button.
// PWR_HOLD_EN undefined: powerOn fires on the debounced press, like powerOff.
module drive_input_conditioner
   import drive_pkg::*;
#(
   parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
   parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
   input  logic                       clk,
   input  logic                       rst,
   drive_input_conditioner_if.slave   bus
);

   logic                on_level;
   logic                on_rise;
   logic                off_level;
   logic                off_rise;
   logic                left_level;
   logic                left_rise;
   logic                right_level;
   logic                right_rise;
   logic [SW_WIDTH-1:0] sw_s1;
   logic [SW_WIDTH-1:0] sw_s2;

   debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_on (
      .clk(clk), .rst(rst), .raw(bus.btn_on_raw), .level(on_level), .rise(on_rise)
   );

   debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_off (
      .clk(clk), .rst(rst), .raw(bus.btn_off_raw), .level(off_level), .rise(off_rise)
   );

   debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_left (
      .clk(clk), .rst(rst), .raw(bus.btn_left_raw), .level(left_level), .rise(left_rise)
   );

   debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_right (
      .clk(clk), .rst(rst), .raw(bus.btn_right_raw), .level(right_level), .rise(right_rise)
   );

   // switches are only synchronized; the FSM tolerates their bounce
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         sw_s1 <= bus.sw_raw;
         sw_s2 <= sw_s1;
      end
   end

   assign bus.sw_sync   = sw_s2;
   assign bus.turnLeft  = left_level;
   assign bus.turnRight = right_level;
   assign bus.powerOff  = off_rise;

`ifdef PWR_HOLD_EN
   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

   logic          hold_ok;
   logic [HW-1:0] hcnt;
   logic          fired;
   logic          pon;
   logic          unused_bits;

   // an off press dominates: holding off keeps the hold count at zero
   assign hold_ok = on_level & ~off_level;

   // long-press timer; fired blocks repeats until the press is released
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt  <= '0;
         fired <= 1'b0;
         pon   <= 1'b0;
      end else if (!hold_ok) begin
         hcnt  <= '0;
         fired <= 1'b0;
         pon   <= 1'b0;
      end else begin
         if (hcnt != HOLD_MAX) begin
            hcnt <= hcnt + HW'(1);
         end
         pon   <= (hcnt == HOLD_MAX) & ~fired;
         fired <= fired | (hcnt == HOLD_MAX);
      end
   end

   assign bus.powerOn = pon;
   assign unused_bits = &{1'b0, on_rise, left_rise, right_rise};
`else
   localparam int unsigned unused_hold = HOLD_CYCLES;
   logic unused_bits;

   // short-press power-on; suppressed by a concurrent or held off press
   assign bus.powerOn = on_rise & ~off_rise & ~off_level;
   assign unused_bits = &{1'b0, on_level, left_rise, right_rise};
`endif

endmodule

// File: tb/tb_drive_input_conditioner.sv
// Scoreboard bench for drive_input_conditioner with DB_CYCLES=4, HOLD_CYCLES=16.
// Expected outputs are queued as each stimulus cycle is driven and compared
// one time unit after the following clock edge.
module tb_drive_input_conditioner;

   localparam int unsigned DB   = 4;
   localparam int unsigned HOLD = 16;
`ifdef PWR_HOLD_EN
   localparam bit LONG_PRESS = 1'b1;
`else
   localparam bit LONG_PRESS = 1'b0;
`endif

   typedef struct {
      string      tag;
      logic [8:0] exp;
   } sb_entry_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;
   sb_entry_t   sb_q[$];

   drive_input_conditioner_if bus ();

   drive_input_conditioner #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // {powerOn, powerOff, turnLeft, turnRight, sw_sync}
   function automatic logic [8:0] out_vec();
      return {bus.powerOn, bus.powerOff, bus.turnLeft, bus.turnRight, bus.sw_sync};
   endfunction

   task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // drive one cycle of stimulus and queue the outputs expected after the next edge
   task automatic step(input logic r, input logic on, input logic off, input logic lft,
                       input logic rgt, input logic [4:0] sw, input logic [8:0] exp,
                       input string tag);
      sb_entry_t e;
      @(negedge clk);
      bus.btn_on_raw    = on;
      bus.btn_off_raw   = off;
      bus.btn_left_raw  = lft;
      bus.btn_right_raw = rgt;
      bus.sw_raw        = sw;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
      if (r && !rst) begin
         rst = 1'b1;
         #1;
         check({tag, "_async"}, out_vec(), '0);
      end else begin
         rst = r;
      end
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, '0, "reset");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, '0, "reset");
   endtask

   // scoreboard monitor
   initial begin
      sb_entry_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check(e.tag, out_vec(), e.exp);
         end
      end
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] sw;
      logic [4:0] sw_exp;

      bus.btn_on_raw    = 1'b0;
      bus.btn_off_raw   = 1'b0;
      bus.btn_left_raw  = 1'b0;
      bus.btn_right_raw = 1'b0;
      bus.sw_raw        = 5'b0;
      #2;
      rst = 1'b1;
      #1;
      check("reset_state", out_vec(), '0);
      @(negedge clk);
      rst = 1'b0;

      // left clean press/release, right overlapping: levels pass through together
      do_reset();
      for (int k = 0; k < 18; k++)
         step(1'b0, 1'b0, 1'b0, (k < 10), (k >= 2 && k < 8), 5'b0,
              {1'b0, 1'b0, (k >= 5 && k < 15), (k >= 7 && k < 13), 5'b0}, "turn");

      // off button bounces 1,0,1,0 then holds: a single powerOff 6 edges after stable
      do_reset();
      for (int k = 0; k < 23; k++)
         step(1'b0, 1'b0, (k < 4) ? (k % 2 == 0) : (k < 15), 1'b0, 1'b0, 5'b0,
              {1'b0, (k == 10), 1'b0, 1'b0, 5'b0}, "off_bounce");

      // on held 30, released 10, held 10
      do_reset();
      for (int k = 0; k < 60; k++)
         step(1'b0, (k < 30) || (k >= 40 && k < 50), 1'b0, 1'b0, 1'b0, 5'b0,
              {LONG_PRESS ? (k == 21) : (k == 6 || k == 46), 1'b0, 1'b0, 1'b0, 5'b0},
              "on_hold");

      // on held, off pressed at cycle 10: power-off dominates
      do_reset();
      for (int k = 0; k < 55; k++)
         step(1'b0, (k < 41), (k >= 10 && k < 41), 1'b0, 1'b0, 5'b0,
              {LONG_PRESS ? 1'b0 : (k == 6), (k == 16), 1'b0, 1'b0, 5'b0}, "on_off");

      // switch synchronizer latency across three patterns
      do_reset();
      for (int k = 0; k < 14; k++) begin
         sw     = (k < 5) ? 5'b10110 : (k < 10) ? 5'b01001 : 5'b00000;
         sw_exp = (k < 1) ? 5'b00000 : (k < 6) ? 5'b10110 : (k < 11) ? 5'b01001 : 5'b00000;
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sw, {4'b0, sw_exp}, "sw_sync");
      end

      // reset in the middle of a hold with buttons kept pressed
      do_reset();
      for (int k = 0; k < 13; k++)
         step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0,
              {1'b0, (k == 6), (k >= 5), 1'b0, 5'b0}, "rst_pre");
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0, '0, "rst_mid");
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0, '0, "rst_mid");
      for (int j = 0; j < 11; j++)
         step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0,
              {1'b0, (j == 6), (j >= 5), 1'b0, 5'b0}, "rst_post");

      repeat (2) @(posedge clk);
      #2;
      check("sb_drain", 9'(sb_q.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
